dmem_responder: RTL and testbench

Memory-side responder for the controller's data-memory port: it answers `MemRead`/`MemWrite` requests and stalls the core through `busy` until each access completes. It sits between the datapath's ALU-result/RS2 buses and the on-chip data RAM. It models a fixed multi-cycle access latency so the controller's stall path can be exercised ahead of a real cache.

---
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: answers MemRead/MemWrite with a fixed LATENCY-cycle stall on busy.
// Optional last-write bypass (zero-wait read hit) enabled by defining DMEM_BYPASS_EN.
module dmem_responder #(
  parameter int NBITS   = 8,
  parameter int NWORDS  = 32,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             err
);

  localparam int         IW     = $clog2(NWORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             op_wr;
  logic [IW-1:0]    cap_idx;
  logic [NBITS-1:0] cap_wdata;
  logic [NBITS-1:0] rdata_q;
  logic [NBITS-1:0] mem [NWORDS];

  logic             req, hit, start, load_rd;
  logic [IW-1:0]    in_idx, rd_idx;
  logic             unused_addr_hi;

  assign req            = MemRead | MemWrite;
  assign in_idx         = addr[IW-1:0];
  assign unused_addr_hi = ^addr[NBITS-1:IW];
  // With LATENCY=1 the read is loaded on the IDLE->DONE edge, before capture.
  assign rd_idx         = (state == IDLE) ? in_idx : cap_idx;

`ifdef DMEM_BYPASS_EN
  logic             byp_vld;
  logic [IW-1:0]    byp_idx;
  logic [NBITS-1:0] byp_dat;

  assign hit   = (state == IDLE) && MemRead && !MemWrite && byp_vld && (byp_idx == in_idx);
  assign rdata = hit ? byp_dat : rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byp_vld <= 1'b0;
      byp_idx <= '0;
      byp_dat <= '0;
    end else if (state == DONE && op_wr) begin
      byp_vld <= 1'b1;
      byp_idx <= cap_idx;
      byp_dat <= cap_wdata;
    end
  end
`else
  assign hit   = 1'b0;
  assign rdata = rdata_q;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    start     = 1'b0;
    load_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          busy  = 1'b1;
          start = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = DONE;
            load_rd   = !MemWrite;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        busy    = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          load_rd   = !op_wr;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        op_wr     <= MemWrite;
        cap_idx   <= in_idx;
        cap_wdata <= wdata;
      end
      if (load_rd) rdata_q <= mem[rd_idx];
      if (MemRead && MemWrite) err <= 1'b1;
    end
  end

  // An async reset forces IDLE before the next edge, so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (state == DONE && op_wr) mem[cap_idx] <= cap_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (LATENCY 2 and 1) against a word-array model.
module tb_dmem_responder;

  localparam int NW = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mr [2];
  logic       mw [2];
  logic [7:0] ad [2];
  logic [7:0] wd [2];
  logic [7:0] rd [2];
  logic       bs [2];
  logic       er [2];

  always #5 clk = ~clk;

  dmem_responder #(.NBITS(8), .NWORDS(NW), .LATENCY(2)) u_dut_l2 (
    .clock(clk), .reset(rst_n), .MemRead(mr[0]), .MemWrite(mw[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd[0]), .busy(bs[0]), .err(er[0])
  );

  dmem_responder #(.NBITS(8), .NWORDS(NW), .LATENCY(1)) u_dut_l1 (
    .clock(clk), .reset(rst_n), .MemRead(mr[1]), .MemWrite(mw[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd[1]), .busy(bs[1]), .err(er[1])
  );

  int         lat [2] = '{2, 1};
  logic [7:0] mem_m [2][NW];
  logic [7:0] rdq_m [2];
  bit         err_m [2];
  bit         lw_vld [2];
  int         lw_idx [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access: drive, count stall cycles, check DONE outputs, then drop the request.
  task automatic access(int d, bit r, bit w, logic [7:0] a, logic [7:0] data);
    int idx;
    bit hit;
    int exp_stall;
    int n;
    idx = int'(a) % NW;
    hit = 1'b0;
    n   = 0;
`ifdef DMEM_BYPASS_EN
    hit = r && !w && lw_vld[d] && (lw_idx[d] == idx);
`endif
    exp_stall = hit ? 0 : lat[d];
    @(negedge clk);
    mr[d] = r; mw[d] = w; ad[d] = a; wd[d] = data;
    #1;
    while (bs[d] === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check($sformatf("stall%0d_a%0d", d, a), n, exp_stall);
    if (r && !w) begin
      if (!hit) rdq_m[d] = mem_m[d][idx];
      check($sformatf("rdata%0d_a%0d", d, a), rd[d], mem_m[d][idx]);
    end else begin
      check($sformatf("rdata_hold%0d", d), rd[d], rdq_m[d]);
    end
    if (w) begin
      mem_m[d][idx] = data;
      lw_vld[d]     = 1'b1;
      lw_idx[d]     = idx;
    end
    if (r && w) err_m[d] = 1'b1;
    check($sformatf("err%0d", d), er[d], err_m[d]);
    mr[d] = 1'b0; mw[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mr[d] = 0; mw[d] = 0; ad[d] = 0; wd[d] = 0;
      rdq_m[d] = 0; err_m[d] = 0; lw_vld[d] = 0; lw_idx[d] = 0;
    end
    rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d), bs[d], 0);
      check($sformatf("rst_rdata%0d", d), rd[d], 0);
      check($sformatf("rst_err%0d", d), er[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NW; i++)
        access(d, 0, 1, 8'(i), 8'($urandom));

    access(0, 0, 1, 8'd5, 8'hA3);
    access(0, 1, 0, 8'd5, 8'h00);
    access(1, 0, 1, 8'd5, 8'h5C);
    access(1, 1, 0, 8'd37, 8'h00);
    access(0, 1, 1, 8'd3, 8'h11);
    access(0, 1, 0, 8'd3, 8'h00);

    // Write 0xFF to word 7, then reset mid-WAIT: the write must be lost.
    @(negedge clk);
    mw[0] = 1'b1; ad[0] = 8'd7; wd[0] = 8'hFF;
    @(posedge clk);
    #3;
    check("midwait_busy", bs[0], 1);
    rst_n = 1'b0;
    mw[0] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_busy%0d", d), bs[d], 0);
      check($sformatf("arst_rdata%0d", d), rd[d], 0);
      check($sformatf("arst_err%0d", d), er[d], 0);
      err_m[d] = 0; rdq_m[d] = 0; lw_vld[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1, 0, 8'd7, 8'h00);

    access(0, 0, 1, 8'd9, 8'h42);
    access(0, 1, 0, 8'd9, 8'h00);
    access(0, 1, 0, 8'd10, 8'h00);

    for (int k = 0; k < 300; k++) begin
      int d;
      int op;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 19));
      if (op < 11)      access(d, 1, 0, 8'($urandom_range(0, 255)), 8'($urandom));
      else if (op < 19) access(d, 0, 1, 8'($urandom_range(0, 255)), 8'($urandom));
      else              access(d, 1, 1, 8'($urandom_range(0, 255)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
